// File: rtl/text_display_pkg.sv
// -----------------------------------------------------------------------------
// text_display_pkg
// Shared definitions for the text display path (glyph buffer, font ROM,
// renderer).
//   - default character-code width, glyph-row width and rows per glyph
//   - row sequencer state encoding
//   - rom_addr_pack(): builds the font ROM address {char, row}
// -----------------------------------------------------------------------------
package text_display_pkg;

  localparam int unsigned CHAR_W_DEF     = 7;
  localparam int unsigned ROW_W_DEF      = 3;
  localparam int unsigned GLYPH_ROWS_DEF = 8;

  // Row sequencer state. The glyph buffer derives it from occupancy.
  typedef enum logic [0:0] {
    SEQ_IDLE = 1'b0,
    SEQ_EMIT = 1'b1
  } seq_state_e;

  // Font ROM address = character code shifted above the row index.
  // Inputs are carried wide so one helper serves every width; callers
  // size-cast the result down to CHAR_W+ROW_W.
  function automatic logic [31:0] rom_addr_pack(
    input logic [15:0] char_code,
    input logic [15:0] row_idx,
    input int unsigned row_w
  );
    logic [31:0] addr_v;
    addr_v = (32'(char_code) << row_w) | 32'(row_idx);
    return addr_v;
  endfunction

endpackage : text_display_pkg

// File: rtl/text_display_char_ring.sv
// -----------------------------------------------------------------------------
// text_display_char_ring
// DEPTH x CHAR_W circular character store with read/write pointers and an
// occupancy count. The storage array itself is not reset; only the pointers
// and count are.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (priority over flush)
//   flush    in   synchronous clear; a push/pop in the same cycle is dropped
//   push     in   write wr_data at the write pointer (ignored when full)
//   pop      in   retire the head entry (ignored when empty)
//   wr_data  in   CHAR_W  character code to store
//   rd_data  out  CHAR_W  head character (entry at the read pointer)
//   count    out  CNT_W   entries held, 0..DEPTH
//   full     out  count == DEPTH
//   empty    out  count == 0
// -----------------------------------------------------------------------------
module text_display_char_ring
  import text_display_pkg::*;
#(
  parameter int unsigned CHAR_W = CHAR_W_DEF,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [CHAR_W-1:0] wr_data,
  output logic [CHAR_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [CHAR_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              full_s;
  logic              empty_s;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full_s  = (count_r == CNT_W'(DEPTH));
  assign empty_s = (count_r == {CNT_W{1'b0}});

  // Qualify requests: never overfill, never underflow, drop during clear.
  always_comb begin
    push_ok_s = 1'b0;
    pop_ok_s  = 1'b0;
    if (rst || flush) begin
      push_ok_s = 1'b0;
      pop_ok_s  = 1'b0;
    end else begin
      push_ok_s = push & ~full_s;
      pop_ok_s  = pop & ~empty_s;
    end
  end

  // Character storage; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy state. DEPTH is a power of two, so the pointers
  // wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;
  assign full    = full_s;
  assign empty   = empty_s;

endmodule : text_display_char_ring

// File: rtl/text_display_glyph_buffer.sv
// -----------------------------------------------------------------------------
// text_display_glyph_buffer
// Character buffer between the text FIFO and the font ROM. Holds up to DEPTH
// character codes and replays the head code for GLYPH_ROWS consecutive ROM
// reads, presenting rom_addr = {char, row}. The head is retired after its
// last row is consumed.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset (priority over flush)
//   flush      in   synchronous clear of buffer and row counter
//   in_valid   in   upstream character valid
//   in_ready   out  buffer can accept a character (count != DEPTH)
//   in_char    in   CHAR_W        character code from the FIFO
//   out_valid  out  rom_addr valid (count != 0)
//   out_ready  in   ROM side consumes rom_addr this cycle
//   rom_addr   out  CHAR_W+ROW_W  {head char, row}; 0 when out_valid=0
//   out_last   out  current row is the glyph's last row (and out_valid)
//   count      out  CNT_W         characters held, 0..DEPTH
// All outputs depend only on registered state; nothing passes through
// combinationally from in_* to in_ready or the output side.
// -----------------------------------------------------------------------------
module text_display_glyph_buffer
  import text_display_pkg::*;
#(
  parameter int unsigned CHAR_W     = CHAR_W_DEF,
  parameter int unsigned ROW_W      = ROW_W_DEF,
  parameter int unsigned GLYPH_ROWS = GLYPH_ROWS_DEF,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CHAR_W-1:0]       in_char,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CHAR_W+ROW_W-1:0] rom_addr,
  output logic                    out_last,
  output logic [CNT_W-1:0]        count
);

  localparam int unsigned ADDR_W = CHAR_W + ROW_W;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GLYPH_ROWS - 1);

  logic [ROW_W-1:0]  row_r;
  logic [ROW_W-1:0]  row_next_s;
  logic [CHAR_W-1:0] head_char_s;
  logic [CNT_W-1:0]  ring_count_s;
  logic              ring_full_s;
  logic              ring_empty_s;
  logic              push_s;
  logic              pop_s;
  logic              beat_s;
  logic              last_row_s;
  seq_state_e        seq_state_s;

  // Handshakes. in_ready comes from the registered full flag only, so a pop
  // while full does not admit a push in the same cycle.
  assign push_s     = in_valid & ~ring_full_s;
  assign last_row_s = (row_r == LAST_ROW);
  assign beat_s     = (seq_state_s == SEQ_EMIT) & out_ready;
  assign pop_s      = beat_s & last_row_s;

  text_display_char_ring #(
    .CHAR_W (CHAR_W),
    .DEPTH  (DEPTH)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (in_char),
    .rd_data (head_char_s),
    .count   (ring_count_s),
    .full    (ring_full_s),
    .empty   (ring_empty_s)
  );

  // Sequencer state decode: EMIT whenever a character is held.
  always_comb begin
    seq_state_s = SEQ_IDLE;
    if (ring_empty_s) begin
      seq_state_s = SEQ_IDLE;
    end else begin
      seq_state_s = SEQ_EMIT;
    end
  end

  // Next row: advance on each consumed beat, back to 0 after the last row.
  always_comb begin
    row_next_s = row_r;
    if (beat_s) begin
      if (last_row_s) begin
        row_next_s = {ROW_W{1'b0}};
      end else begin
        row_next_s = row_r + ROW_W'(1);
      end
    end else begin
      row_next_s = row_r;
    end
  end

  // Row counter register; flush behaves like reset for the sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_r <= {ROW_W{1'b0}};
    end else if (flush) begin
      row_r <= {ROW_W{1'b0}};
    end else begin
      row_r <= row_next_s;
    end
  end

  // Output decode from sequencer state; rom_addr is masked to 0 when idle.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    rom_addr  = {ADDR_W{1'b0}};
    case (seq_state_s)
      SEQ_EMIT: begin
        out_valid = 1'b1;
        out_last  = last_row_s;
        rom_addr  = ADDR_W'(rom_addr_pack(16'(head_char_s), 16'(row_r), ROW_W));
      end
      SEQ_IDLE: begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        rom_addr  = {ADDR_W{1'b0}};
      end
      default: begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        rom_addr  = {ADDR_W{1'b0}};
      end
    endcase
  end

  assign in_ready = ~ring_full_s;
  assign count    = ring_count_s;

endmodule : text_display_glyph_buffer

// File: tb/tb_text_display_glyph_buffer.sv
// -----------------------------------------------------------------------------
// tb_text_display_glyph_buffer
// Directed self-checking bench for text_display_glyph_buffer with default
// parameters (CHAR_W=7, ROW_W=3, GLYPH_ROWS=8, DEPTH=4). Inputs change 1 time
// unit after each rising edge; outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_text_display_glyph_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] in_char = 7'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [9:0] rom_addr;
  logic       out_last;
  logic [2:0] count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  text_display_glyph_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_char   (in_char),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rom_addr  (rom_addr),
    .out_last  (out_last),
    .count     (count)
  );

  function automatic logic [9:0] addr_of(input logic [6:0] c, input int r);
    logic [2:0] r3;
    r3 = 3'(r);
    return {c, r3};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    n_vec++; if (rom_addr !== 10'h000) begin n_err++; $display("FAIL reset_rom_addr got %h exp 000", rom_addr); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
    n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last got %0b exp 0", out_last); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [9:0] exp_a;
    in_valid  = 1'b1;
    in_char   = 7'h41;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_vec++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count got %0d exp 1", count); end
    for (int i = 0; i < 8; i++) begin
      exp_a = 10'h208 + 10'(i);
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid row %0d got %0b exp 1", i, out_valid); end
      n_vec++; if (rom_addr !== exp_a) begin n_err++; $display("FAIL single_addr row %0d got %h exp %h", i, rom_addr, exp_a); end
      n_vec++; if (out_last !== (i == 7)) begin n_err++; $display("FAIL single_last row %0d got %0b exp %0b", i, out_last, (i == 7)); end
      step();
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_done_valid got %0b exp 0", out_valid); end
    n_vec++; if (rom_addr !== 10'h000) begin n_err++; $display("FAIL single_done_addr got %h exp 000", rom_addr); end
    out_ready = 1'b0;
  endtask

  task automatic test_fill();
    logic [6:0] c;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      c = 7'h50 + 7'(k);
      in_valid = 1'b1;
      in_char  = c;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready k=%0d got %0b exp 1", k, in_ready); end
      step();
      n_vec++; if (count !== 3'(k + 1)) begin n_err++; $display("FAIL fill_count k=%0d got %0d exp %0d", k, count, k + 1); end
    end
    in_char = 7'h54;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_full_ready got %0b exp 0", in_ready); end
    step();
    n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_held_count got %0d exp 4", count); end
    n_vec++; if (rom_addr !== addr_of(7'h50, 0)) begin n_err++; $display("FAIL fill_head got %h exp %h", rom_addr, addr_of(7'h50, 0)); end
    out_ready = 1'b1;
    for (int j = 0; j < 7; j++) step();
    n_vec++; if (out_last !== 1'b1) begin n_err++; $display("FAIL fill_last got %0b exp 1", out_last); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready_before_pop got %0b exp 0", in_ready); end
    step();
    // Pop happened while full: the held 5th char must not have entered.
    n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL fill_after_pop_count got %0d exp 3", count); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_after_pop_ready got %0b exp 1", in_ready); end
    n_vec++; if (rom_addr !== addr_of(7'h51, 0)) begin n_err++; $display("FAIL fill_after_pop_head got %h exp %h", rom_addr, addr_of(7'h51, 0)); end
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_fifth_count got %0d exp 4", count); end
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      c = 7'h50 + 7'(k);
      for (int r = 0; r < 8; r++) begin
        n_vec++; if (rom_addr !== addr_of(c, r)) begin n_err++; $display("FAIL fill_drain char %h row %0d got %h exp %h", c, r, rom_addr, addr_of(c, r)); end
        step();
      end
    end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL fill_empty_count got %0d exp 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int row;
    in_valid  = 1'b1;
    in_char   = 7'h12;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    row = 0;
    for (int t = 0; t < 16; t++) begin
      out_ready = t[0];
      n_vec++; if (rom_addr !== addr_of(7'h12, row)) begin n_err++; $display("FAIL bp_addr t=%0d got %h exp %h", t, rom_addr, addr_of(7'h12, row)); end
      step();
      if (t[0]) row++;
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_done_valid got %0b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int exp_cnt, sent, rcv, row, cyc;
    bit push, beat;
    logic [6:0] exp_c;
    exp_cnt = 0; sent = 0; rcv = 0; row = 0; cyc = 0;
    while (rcv < 10 && cyc < 400) begin
      in_valid  = (sent < 10);
      in_char   = 7'h30 + 7'(sent);
      out_ready = 1'($urandom_range(0, 1));
      exp_c     = 7'h30 + 7'(rcv);
      n_vec++; if (out_valid !== (exp_cnt != 0)) begin n_err++; $display("FAIL wrap_valid cyc %0d got %0b exp %0b", cyc, out_valid, (exp_cnt != 0)); end
      n_vec++; if (in_ready !== (exp_cnt != 4)) begin n_err++; $display("FAIL wrap_ready cyc %0d got %0b exp %0b", cyc, in_ready, (exp_cnt != 4)); end
      n_vec++; if (count !== 3'(exp_cnt)) begin n_err++; $display("FAIL wrap_count cyc %0d got %0d exp %0d", cyc, count, exp_cnt); end
      if (exp_cnt != 0) begin
        n_vec++; if (rom_addr !== addr_of(exp_c, row)) begin n_err++; $display("FAIL wrap_addr cyc %0d got %h exp %h", cyc, rom_addr, addr_of(exp_c, row)); end
        n_vec++; if (out_last !== (row == 7)) begin n_err++; $display("FAIL wrap_last cyc %0d got %0b exp %0b", cyc, out_last, (row == 7)); end
      end
      push = in_valid && (exp_cnt != 4);
      beat = out_ready && (exp_cnt != 0);
      step();
      if (push) begin sent++; exp_cnt++; end
      if (beat) begin
        if (row == 7) begin row = 0; rcv++; exp_cnt--; end
        else row++;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_vec++; if (rcv != 10) begin n_err++; $display("FAIL wrap_timeout got %0d chars exp 10", rcv); end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL wrap_end_count got %0d exp 0", count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_char = 7'h61 + 7'(k);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) step();
    out_ready = 1'b0;
    n_vec++; if (rom_addr !== addr_of(7'h61, 3)) begin n_err++; $display("FAIL flush_pre_addr got %h exp %h", rom_addr, addr_of(7'h61, 3)); end
    n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL flush_pre_count got %0d exp 3", count); end
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_char   = 7'h77;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_count got %0d exp 0", count); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %0b exp 0", out_valid); end
    n_vec++; if (rom_addr !== 10'h000) begin n_err++; $display("FAIL flush_addr got %h exp 000", rom_addr); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got %0b exp 1", in_ready); end
    in_valid = 1'b1;
    in_char  = 7'h22;
    step();
    in_valid = 1'b0;
    n_vec++; if (count !== 3'd1) begin n_err++; $display("FAIL flush_repush_count got %0d exp 1", count); end
    n_vec++; if (rom_addr !== addr_of(7'h22, 0)) begin n_err++; $display("FAIL flush_row0 got %h exp %h", rom_addr, addr_of(7'h22, 0)); end
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) step();
    out_ready = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_drain_valid got %0b exp 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_backpressure();
    test_wrap();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_text_display_glyph_buffer
